// File: rtl/fifo_ctrl_pkg.sv
// Shared types for the FIFO pointer/flag controller.
package fifo_ctrl_pkg;

  // Operation accepted at a clock edge, encoded as {read_accept, write_accept}.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_BOTH  = 2'b11
  } op_e;

  // Classify the accepted requests for one edge.
  function automatic op_e decode_op(input logic wr_acc, input logic rd_acc);
    return op_e'({rd_acc, wr_acc});
  endfunction

endpackage

// File: rtl/fifo_ctrl.sv
// Pointer and flag controller for a register-file FIFO. Produces the storage
// array's write enable and addresses, tracks occupancy, and keeps sticky
// overflow/underflow error flags.
//
// Request semantics: wr and rd are level requests sampled at each rising edge.
// A write is accepted when wr is high and full (registered) is low; a read is
// accepted when rd is high and empty (registered) is low. Acceptance of each
// side depends only on the flags registered before the edge, so there is no
// bypass from an empty FIFO and no combinational path from rd to any output.
// Read data is the array's combinational output at r_addr, valid while empty=0.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 2,
  parameter int AF_LEVEL   = 3,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  input  logic                  clr_err,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(AE_LEVEL);

  // Elaboration-time legality of the parameter set.
  if (ADDR_WIDTH < 1) begin : g_bad_addr_width
    $error("fifo_ctrl: ADDR_WIDTH must be >= 1");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af_level
    $error("fifo_ctrl: AF_LEVEL must be in 1..2**ADDR_WIDTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae_level
    $error("fifo_ctrl: AE_LEVEL must be in 0..2**ADDR_WIDTH-1");
  end

  logic              wr_acc;
  logic              rd_acc;
  op_e               op;
  logic [ADDR_WIDTH:0] count_next;

  // Acceptance is gated only by registered flags; wr reaches wr_en directly.
  assign wr_acc = wr & ~full;
  assign rd_acc = rd & ~empty;
  assign wr_en  = wr_acc;
  assign op     = decode_op(wr_acc, rd_acc);

  // Next occupancy: +1 write-only, -1 read-only, else unchanged.
  always_comb begin
    count_next = count;
    case (op)
      OP_WRITE: count_next = count + 1'b1;
      OP_READ:  count_next = count - 1'b1;
      default:  count_next = count;
    endcase
  end

  // Pointers advance on their own accepts and wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_addr <= '0;
      r_addr <= '0;
    end else begin
      if (wr_acc) w_addr <= w_addr + 1'b1;
      if (rd_acc) r_addr <= r_addr + 1'b1;
    end
  end

  // Occupancy and flags, all derived from the next-state count so that
  // full and empty are never decided by pointer comparison.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      count        <= count_next;
      empty        <= (count_next == '0);
      full         <= (count_next == DEPTH_C);
      almost_full  <= (count_next >= AF_C);
      almost_empty <= (count_next <= AE_C);
    end
  end

  // Sticky errors; a new error event in the clearing cycle takes priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (wr & full)  | (overflow  & ~clr_err);
      underflow <= (rd & empty) | (underflow & ~clr_err);
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with a small storage array wired to its
// write enable and addresses, so data ordering can be observed.
module tb_fifo_ctrl;

  localparam int AW = 2;

  logic          clk;
  logic          reset;
  logic          wr;
  logic          rd;
  logic          clr_err;
  logic          wr_en;
  logic [AW-1:0] w_addr;
  logic [AW-1:0] r_addr;
  logic          empty;
  logic          full;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  logic [7:0] din;
  logic [7:0] mem [4];
  logic [7:0] rdata;
  logic [3:0] flags;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  fifo_ctrl #(.ADDR_WIDTH(AW), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
    .clk(clk), .reset(reset), .wr(wr), .rd(rd), .clr_err(clr_err),
    .wr_en(wr_en), .w_addr(w_addr), .r_addr(r_addr),
    .empty(empty), .full(full), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  // Clock and storage array.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (wr_en) mem[w_addr] <= din;
  assign rdata = mem[r_addr];
  assign flags = {empty, full, almost_full, almost_empty};

  // Driver tasks: drive at negedge, observe 1ns after the posedge.
  task automatic drive(input logic w, input logic r, input logic c, input logic [7:0] d);
    @(negedge clk);
    wr = w; rd = r; clr_err = c; din = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr = 1'b0; rd = 1'b0; clr_err = 1'b0; din = '0;
    repeat (2) @(negedge clk);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if ({w_addr, r_addr} !== 4'h0) begin errors++; $display("FAIL reset_addrs got %h exp 0", {w_addr, r_addr}); end
    checks++; if (flags !== 4'b1001) begin errors++; $display("FAIL reset_flags got %b exp 1001", flags); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_errs got %b exp 00", {overflow, underflow}); end
    reset = 1'b0;
    tick();
    checks++; if ({wr_en, count} !== 4'h0) begin errors++; $display("FAIL idle got wr_en=%b count=%0d exp 0 0", wr_en, count); end
    drive(1, 0, 0, 8'h11); tick();
    drive(1, 0, 0, 8'h22); tick();
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL pre_async_count got %0d exp 2", count); end
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    checks++; if (count !== 3'd0 || w_addr !== 2'd0 || flags !== 4'b1001) begin
      errors++; $display("FAIL async_reset got count=%0d w_addr=%0d flags=%b exp 0 0 1001", count, w_addr, flags);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_fill();
    logic [3:0] exp_flags [4] = '{4'b0001, 4'b0000, 4'b0010, 4'b0110};
    logic [1:0] exp_wa    [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 8'hA1 + 8'(i));
      checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL fill_wr_en[%0d] got %b exp 1", i, wr_en); end
      tick();
      checks++; if (count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, count, i + 1); end
      checks++; if (flags !== exp_flags[i]) begin errors++; $display("FAIL fill_flags[%0d] got %b exp %b", i, flags, exp_flags[i]); end
      checks++; if (w_addr !== exp_wa[i]) begin errors++; $display("FAIL fill_w_addr[%0d] got %0d exp %0d", i, w_addr, exp_wa[i]); end
    end
    drive(1, 0, 0, 8'hEE);
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL overflow_wr_en got %b exp 0", wr_en); end
    tick();
    checks++; if (overflow !== 1'b1 || w_addr !== 2'd0 || count !== 3'd4) begin
      errors++; $display("FAIL overflow got ovf=%b w_addr=%0d count=%0d exp 1 0 4", overflow, w_addr, count);
    end
  endtask

  task automatic test_drain();
    logic [3:0] exp_flags [4] = '{4'b0010, 4'b0000, 4'b0001, 4'b1001};
    logic [1:0] exp_ra    [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 8'h00);
      checks++; if (rdata !== 8'hA1 + 8'(i)) begin errors++; $display("FAIL drain_data[%0d] got %h exp %h", i, rdata, 8'hA1 + 8'(i)); end
      tick();
      checks++; if (flags !== exp_flags[i]) begin errors++; $display("FAIL drain_flags[%0d] got %b exp %b", i, flags, exp_flags[i]); end
      checks++; if (r_addr !== exp_ra[i]) begin errors++; $display("FAIL drain_r_addr[%0d] got %0d exp %0d", i, r_addr, exp_ra[i]); end
    end
    drive(0, 1, 0, 8'h00); tick();
    checks++; if (underflow !== 1'b1 || r_addr !== 2'd0 || count !== 3'd0) begin
      errors++; $display("FAIL underflow got unf=%b r_addr=%0d count=%0d exp 1 0 0", underflow, r_addr, count);
    end
  endtask

  task automatic test_clr_err();
    drive(0, 0, 1, 8'h00); tick();
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL clr_err got %b exp 00", {overflow, underflow}); end
  endtask

  task automatic test_simultaneous();
    // Empty: write only, read rejected.
    drive(1, 1, 0, 8'h51); tick();
    checks++; if (count !== 3'd1 || underflow !== 1'b1 || w_addr !== 2'd1 || r_addr !== 2'd0) begin
      errors++; $display("FAIL simul_empty got count=%0d unf=%b w=%0d r=%0d exp 1 1 1 0", count, underflow, w_addr, r_addr);
    end
    drive(1, 0, 0, 8'h52); tick();
    // Mid-fill: both advance.
    drive(1, 1, 0, 8'h53);
    checks++; if (rdata !== 8'h51) begin errors++; $display("FAIL simul_mid_data got %h exp 51", rdata); end
    tick();
    checks++; if (count !== 3'd2 || w_addr !== 2'd3 || r_addr !== 2'd1 || flags !== 4'b0000) begin
      errors++; $display("FAIL simul_mid got count=%0d w=%0d r=%0d flags=%b exp 2 3 1 0000", count, w_addr, r_addr, flags);
    end
    drive(1, 0, 0, 8'h54); tick();
    drive(1, 0, 0, 8'h55); tick();
    checks++; if (count !== 3'd4 || full !== 1'b1 || overflow !== 1'b0) begin
      errors++; $display("FAIL simul_prefull got count=%0d full=%b ovf=%b exp 4 1 0", count, full, overflow);
    end
    // Full: read only, write rejected.
    drive(1, 1, 0, 8'hEE);
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL simul_full_wr_en got %b exp 0", wr_en); end
    tick();
    checks++; if (count !== 3'd3 || overflow !== 1'b1 || w_addr !== 2'd1 || r_addr !== 2'd2) begin
      errors++; $display("FAIL simul_full got count=%0d ovf=%b w=%0d r=%0d exp 3 1 1 2", count, overflow, w_addr, r_addr);
    end
    // Refill, clear, then clear racing a new overflow.
    drive(1, 0, 0, 8'h56); tick();
    drive(0, 0, 1, 8'h00); tick();
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL clr_both got %b exp 00", {overflow, underflow}); end
    drive(1, 0, 1, 8'hEF); tick();
    checks++; if (overflow !== 1'b1 || count !== 3'd4 || w_addr !== 2'd2) begin
      errors++; $display("FAIL clr_vs_ovf got ovf=%b count=%0d w=%0d exp 1 4 2", overflow, count, w_addr);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_d;
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0, 8'h30 + 8'(i)); tick();
      exp_q.push_back(8'h30 + 8'(i));
      checks++; if (count !== 3'd1 || w_addr !== 2'((i + 1) % 4)) begin
        errors++; $display("FAIL wrap_write[%0d] got count=%0d w=%0d exp 1 %0d", i, count, w_addr, (i + 1) % 4);
      end
      drive(0, 1, 0, 8'h00);
      exp_d = exp_q.pop_front();
      checks++; if (rdata !== exp_d || r_addr !== 2'(i % 4)) begin
        errors++; $display("FAIL wrap_read[%0d] got data=%h r=%0d exp %h %0d", i, rdata, r_addr, exp_d, i % 4);
      end
      tick();
      checks++; if (count !== 3'd0 || empty !== 1'b1) begin
        errors++; $display("FAIL wrap_empty[%0d] got count=%0d empty=%b exp 0 1", i, count, empty);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_clr_err();
    test_simultaneous();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
